// File: rtl/riscv_pkg.sv
// Shared definitions for the integer execute stage: ALU opcodes, default width,
// branch-op range and shifter direction encoding.
package riscv_pkg;

  localparam int I_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNEQ = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_t;

  localparam alu_op_t BR_OP_FIRST = ALU_BEQ;
  localparam alu_op_t BR_OP_LAST  = ALU_BGEU;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } sh_kind_t;

  function automatic logic is_branch(input alu_op_t op);
    return op inside {[BR_OP_FIRST:BR_OP_LAST]};
  endfunction

  function automatic logic is_shift(input alu_op_t op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath: single-cycle barrel shifter by default, or a one-bit-per-cycle
// serial shifter with its own IDLE/SHIFT FSM when ALU_SERIAL_SHIFT_EN is defined.
module alu_shifter
  import riscv_pkg::*;
#(
  parameter int W    = riscv_pkg::I_WIDTH,
  parameter int SH_W = $clog2(W)
) (
  input  sh_kind_t         kind,
  input  logic [W-1:0]     data_in,
  input  logic [SH_W-1:0]  shamt,
  output logic [W-1:0]     comb_out
`ifdef ALU_SERIAL_SHIFT_EN
  ,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     serial_out
`endif
);

`ifdef ALU_SERIAL_SHIFT_EN

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t          state_q, state_d;
  logic [SH_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [W-1:0]    sreg_shifted;
  sh_kind_t        kind_q, kind_d;

  // A zero shift amount never starts the FSM, so the operand passes straight through.
  assign comb_out = data_in;

  always_comb begin
    sreg_shifted = sreg_q;
    case (kind_q)
      SH_LL:   sreg_shifted = {sreg_q[W-2:0], 1'b0};
      SH_RL:   sreg_shifted = {1'b0, sreg_q[W-1:1]};
      SH_RA:   sreg_shifted = {sreg_q[W-1], sreg_q[W-1:1]};
      default: sreg_shifted = sreg_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    kind_d  = kind_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (shamt != '0)) begin
          state_d = ST_SHIFT;
          cnt_d   = shamt;
          sreg_d  = data_in;
          kind_d  = kind;
        end
      end
      ST_SHIFT: begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      kind_q  <= SH_LL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      kind_q  <= kind_d;
    end
  end

  // The last shift step is computed combinationally so the top can capture it on the same edge.
  assign busy       = (state_q == ST_SHIFT);
  assign done       = busy && (cnt_q == SH_W'(1));
  assign serial_out = sreg_shifted;

`else

  always_comb begin
    comb_out = data_in;
    case (kind)
      SH_LL:   comb_out = data_in << shamt;
      SH_RL:   comb_out = data_in >> shamt;
      SH_RA:   comb_out = W'($signed(data_in) >>> shamt);
      default: comb_out = data_in;
    endcase
  end

`endif

endmodule

// File: rtl/alu_exec.sv
// RISC-V execute stage: ALU/compare datapath with a registered, valid/ready result.
// Build option ALU_SERIAL_SHIFT_EN selects serial (1 bit/cycle) shifts.
module alu_exec
  import riscv_pkg::*;
#(
  parameter int I_WIDTH = riscv_pkg::I_WIDTH,
  parameter int SH_W    = $clog2(I_WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [I_WIDTH-1:0] d1In,
  input  logic [I_WIDTH-1:0] d2In,
  input  logic [4:0]         rd_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] result,
  output logic               br_taken,
  output logic [4:0]         rd_out
);

  alu_op_t            op;
  logic [SH_W-1:0]    shamt;
  sh_kind_t           sh_kind;
  logic [I_WIDTH-1:0] sh_comb;
  logic [I_WIDTH-1:0] alu_res;
  logic               alu_br;
  logic               sh_busy;
  logic               accept;
  logic               start_serial;

  logic               run_q, run_d;
  logic               out_valid_q, out_valid_d;
  logic [I_WIDTH-1:0] result_q, result_d;
  logic               br_q, br_d;
  logic [4:0]         rd_q, rd_d;

  assign op    = alu_op_t'(alu_op);
  assign shamt = d2In[SH_W-1:0];

  always_comb begin
    case (op)
      ALU_SLL: sh_kind = SH_LL;
      ALU_SRL: sh_kind = SH_RL;
      default: sh_kind = SH_RA;
    endcase
  end

`ifdef ALU_SERIAL_SHIFT_EN
  logic               sh_done;
  logic [I_WIDTH-1:0] sh_serial;
  logic [4:0]         rd_pend_q, rd_pend_d;

  assign start_serial = accept && is_shift(op) && (shamt != '0);

  alu_shifter #(.W(I_WIDTH), .SH_W(SH_W)) u_shifter (
    .kind       (sh_kind),
    .data_in    (d1In),
    .shamt      (shamt),
    .comb_out   (sh_comb),
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_serial),
    .busy       (sh_busy),
    .done       (sh_done),
    .serial_out (sh_serial)
  );
`else
  assign start_serial = 1'b0;
  assign sh_busy      = 1'b0;

  alu_shifter #(.W(I_WIDTH), .SH_W(SH_W)) u_shifter (
    .kind     (sh_kind),
    .data_in  (d1In),
    .shamt    (shamt),
    .comb_out (sh_comb)
  );
`endif

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (op)
      ALU_ADD:  alu_res = d1In + d2In;
      ALU_SUB:  alu_res = d1In - d2In;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_res = sh_comb;
      ALU_SLT:  alu_res = I_WIDTH'($signed(d1In) < $signed(d2In));
      ALU_SLTU: alu_res = I_WIDTH'(d1In < d2In);
      ALU_XOR:  alu_res = d1In ^ d2In;
      ALU_OR:   alu_res = d1In | d2In;
      ALU_AND:  alu_res = d1In & d2In;
      ALU_BEQ:  alu_br  = (d1In == d2In);
      ALU_BNEQ: alu_br  = (d1In != d2In);
      ALU_BLT:  alu_br  = ($signed(d1In) < $signed(d2In));
      ALU_BGE:  alu_br  = ($signed(d1In) >= $signed(d2In));
      ALU_BLTU: alu_br  = (d1In < d2In);
      ALU_BGEU: alu_br  = (d1In >= d2In);
      default:  alu_res = '0;
    endcase
    if (is_branch(op)) alu_res = I_WIDTH'(alu_br);
  end

  // run_q holds off acceptance for the first cycle after reset release.
  assign in_ready = run_q && !sh_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    run_d       = 1'b1;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    br_d        = br_q;
    rd_d        = rd_q;
`ifdef ALU_SERIAL_SHIFT_EN
    rd_pend_d   = rd_pend_q;
    if (start_serial) rd_pend_d = rd_in;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && !start_serial) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      br_d        = alu_br;
      rd_d        = rd_in;
    end
`ifdef ALU_SERIAL_SHIFT_EN
    if (sh_done) begin
      out_valid_d = 1'b1;
      result_d    = sh_serial;
      br_d        = 1'b0;
      rd_d        = rd_pend_q;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= 1'b0;
      rd_q        <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
      rd_pend_q   <= '0;
`endif
    end else begin
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      br_q        <= br_d;
      rd_q        <= rd_d;
`ifdef ALU_SERIAL_SHIFT_EN
      rd_pend_q   <= rd_pend_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign br_taken  = br_q;
  assign rd_out    = rd_q;

endmodule
